wb_unit_buffered: RTL and testbench

- Parametrised write-back unit for the 16-bit Harvard core.
- Each retiring result goes one of two ways:
  - Register-file write: registered, one cycle.
  - Data-memory store: queued in a store buffer, then drained to data memory over a valid/ready handshake.
- Sits between the execute stage and the register file / data memory. It replaces the fixed, unbuffered routing of the previous write-back.

---
 rtl/wb_unit_buffered.sv | 163 ++++++++++++++++
 tb/tb_wb_unit_buffered.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_unit_buffered.sv
// Write-back unit: register writes retire in one registered cycle.
// Stores queue in a circular buffer and drain to data memory over valid/ready.
module wb_unit_buffered #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int REG_AW   = 6,
    parameter int SB_DEPTH = 4,
    parameter int ZERO_REG = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_is_store,
    input  logic [DATA_W-1:0]               in_data,
    input  logic [ADDR_W-1:0]               in_addr,
    input  logic [REG_AW-1:0]               in_dest,
    output logic                            reg_write_en,
    output logic [REG_AW-1:0]               reg_write_dest,
    output logic [DATA_W-1:0]               reg_write_data,
    output logic                            mem_write_en,
    input  logic                            mem_ready,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_write_data,
    output logic [$clog2(SB_DEPTH+1)-1:0]   sb_count,
    output logic                            sb_empty
);
    localparam int CW = $clog2(SB_DEPTH + 1);
    localparam int PW = $clog2(SB_DEPTH);
    localparam logic [CW-1:0] SB_FULL = CW'(SB_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} drain_state_t;

    drain_state_t      state_r, state_nxt_s;
    logic [ADDR_W-1:0] addr_q_r [SB_DEPTH];
    logic [DATA_W-1:0] data_q_r [SB_DEPTH];
    logic [PW-1:0]     wr_ptr_r, rd_ptr_r, rd_next_s;
    logic [CW-1:0]     count_r, count_nxt_s;
    logic              accept_s, push_s, pop_s, load_s;
    logic [ADDR_W-1:0] load_addr_s;
    logic [DATA_W-1:0] load_data_s;
    logic              mem_write_en_r, sb_empty_r, reg_write_en_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_write_data_r, reg_write_data_r;
    logic [REG_AW-1:0] reg_write_dest_r;

    // Full blocks every retire, register writes included, so retirement stays in order.
    assign in_ready  = !rst && (count_r < SB_FULL);
    assign accept_s  = in_valid && in_ready;
    assign push_s    = accept_s && in_is_store;
    assign rd_next_s = rd_ptr_r + PW'(1);

    // Drain FSM next state; on a handshake with an empty remainder, a same-cycle push is bypassed.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        load_s      = 1'b0;
        load_addr_s = addr_q_r[rd_ptr_r];
        load_data_s = data_q_r[rd_ptr_r];
        case (state_r)
            ST_IDLE: begin
                if (count_r != CNT_ZERO) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
                    pop_s = 1'b1;
                    if (count_r > CNT_ONE) begin
                        load_s      = 1'b1;
                        load_addr_s = addr_q_r[rd_next_s];
                        load_data_s = data_q_r[rd_next_s];
                    end else if (push_s) begin
                        load_s      = 1'b1;
                        load_addr_s = in_addr;
                        load_data_s = in_data;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Occupancy update; the in-flight entry counts until its handshake.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Store buffer storage; contents need no reset since the count guards them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_q_r[wr_ptr_r] <= in_addr;
            data_q_r[wr_ptr_r] <= in_data;
        end
    end

    // Pointers, count, drain state and memory-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            wr_ptr_r         <= {PW{1'b0}};
            rd_ptr_r         <= {PW{1'b0}};
            count_r          <= CNT_ZERO;
            sb_empty_r       <= 1'b1;
            mem_write_en_r   <= 1'b0;
            mem_addr_r       <= {ADDR_W{1'b0}};
            mem_write_data_r <= {DATA_W{1'b0}};
        end else begin
            state_r        <= state_nxt_s;
            count_r        <= count_nxt_s;
            sb_empty_r     <= (count_nxt_s == CNT_ZERO);
            mem_write_en_r <= (state_nxt_s == ST_ISSUE);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_next_s;
            end
            if (load_s) begin
                mem_addr_r       <= load_addr_s;
                mem_write_data_r <= load_data_s;
            end
        end
    end

    // Register-file path: dest/data follow every accepted register write, the strobe skips dest 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_en_r   <= 1'b0;
            reg_write_dest_r <= {REG_AW{1'b0}};
            reg_write_data_r <= {DATA_W{1'b0}};
        end else begin
            reg_write_en_r <= accept_s && !in_is_store &&
                              !((ZERO_REG != 0) && (in_dest == {REG_AW{1'b0}}));
            if (accept_s && !in_is_store) begin
                reg_write_dest_r <= in_dest;
                reg_write_data_r <= in_data;
            end
        end
    end

    assign reg_write_en   = reg_write_en_r;
    assign reg_write_dest = reg_write_dest_r;
    assign reg_write_data = reg_write_data_r;
    assign mem_write_en   = mem_write_en_r;
    assign mem_addr       = mem_addr_r;
    assign mem_write_data = mem_write_data_r;
    assign sb_count       = count_r;
    assign sb_empty       = sb_empty_r;
endmodule

// File: tb/tb_wb_unit_buffered.sv
// Self-checking bench for wb_unit_buffered: scenario tasks plus a cycle monitor
// comparing against a queue-based model of retire/store ordering.
module tb_wb_unit_buffered;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_is_store;
    logic [15:0] in_data, in_addr;
    logic [5:0]  in_dest;
    logic        reg_write_en;
    logic [5:0]  reg_write_dest;
    logic [15:0] reg_write_data;
    logic        mem_write_en, mem_ready;
    logic [15:0] mem_addr, mem_write_data;
    logic [2:0]  sb_count;
    logic        sb_empty;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    logic [31:0] exp_q[$];
    logic        exp_reg_upd = 1'b0;
    logic        exp_reg_en = 1'b0;
    logic [5:0]  exp_dest;
    logic [15:0] exp_data;

    wb_unit_buffered dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
        .in_data(in_data), .in_addr(in_addr), .in_dest(in_dest),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
        .reg_write_data(reg_write_data),
        .mem_write_en(mem_write_en), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .sb_count(sb_count), .sb_empty(sb_empty)
    );

    always #5 clk = ~clk;

    // Reference model: stores leave in acceptance order, occupancy is the queue length.
    always @(negedge clk) begin
        logic [31:0] tmp;
        logic        acc, hs;
        if (rst) begin
            checks++;
            if (sb_count !== 3'd0 || mem_write_en !== 1'b0 || in_ready !== 1'b0 ||
                reg_write_en !== 1'b0 || sb_empty !== 1'b1) begin
                errors++;
                $display("FAIL mon_in_reset: cnt=%0d mwe=%b rdy=%b rwe=%b empty=%b",
                         sb_count, mem_write_en, in_ready, reg_write_en, sb_empty);
            end
            exp_q.delete();
            exp_reg_upd = 1'b0;
            exp_reg_en  = 1'b0;
        end else begin
            checks++;
            if (sb_count !== 3'(exp_q.size()) || in_ready !== (exp_q.size() < 4) ||
                sb_empty !== (exp_q.size() == 0)) begin
                errors++;
                $display("FAIL mon_count: cnt=%0d rdy=%b empty=%b, expected cnt=%0d",
                         sb_count, in_ready, sb_empty, exp_q.size());
            end
            checks++;
            if (reg_write_en !== exp_reg_en ||
                (exp_reg_upd && (reg_write_dest !== exp_dest || reg_write_data !== exp_data))) begin
                errors++;
                $display("FAIL mon_reg: en=%b dest=%0d data=%h, expected en=%b dest=%0d data=%h",
                         reg_write_en, reg_write_dest, reg_write_data, exp_reg_en, exp_dest, exp_data);
            end
            if (mem_write_en) begin
                checks++;
                if (exp_q.size() == 0 || {mem_addr, mem_write_data} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL mon_store_head: got addr=%h data=%h, expected %h (queue %0d)",
                             mem_addr, mem_write_data, (exp_q.size() > 0) ? exp_q[0] : 32'h0,
                             exp_q.size());
                end
            end
            acc = in_valid && (exp_q.size() < 4);
            hs  = mem_write_en && mem_ready;
            if (hs && exp_q.size() > 0) begin
                tmp = exp_q.pop_front();
                hs_cnt++;
            end
            if (acc && in_is_store) exp_q.push_back({in_addr, in_data});
            exp_reg_upd = acc && !in_is_store;
            exp_reg_en  = acc && !in_is_store && (in_dest != 6'd0);
            exp_dest    = in_dest;
            exp_data    = in_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        while (!sb_empty && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (sb_empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_timeout: sb_empty=%b cnt=%0d required empty", sb_empty, sb_count);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (reg_write_en !== 1'b0 || mem_write_en !== 1'b0 || sb_count !== 3'd0 ||
            sb_empty !== 1'b1 || in_ready !== 1'b0 || mem_addr !== 16'h0 || reg_write_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: rwe=%b mwe=%b cnt=%0d empty=%b rdy=%b, required 0/0/0/1/0",
                     reg_write_en, mem_write_en, sb_count, sb_empty, in_ready);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
        // Mid-drain reset with three stores buffered.
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_is_store = 1'b1;
            in_addr = 16'($urandom); in_data = 16'($urandom);
            step();
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (mem_write_en !== 1'b1 || sb_count !== 3'd3) begin
            errors++;
            $display("FAIL reset_pre_state: mwe=%b cnt=%0d required 1/3", mem_write_en, sb_count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_write_en !== 1'b0 || sb_count !== 3'd0 || in_ready !== 1'b0 || sb_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_drain: mwe=%b cnt=%0d rdy=%b empty=%b required 0/0/0/1",
                     mem_write_en, sb_count, in_ready, sb_empty);
        end
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_held: got %b required 0", in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || sb_count !== 3'd0 || mem_write_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_after: rdy=%b cnt=%0d mwe=%b required 1/0/0", in_ready, sb_count, mem_write_en);
        end
    endtask

    task automatic test_reg_write();
        in_valid = 1'b1; in_is_store = 1'b0; in_dest = 6'd5; in_data = 16'h1234;
        step();
        in_valid = 1'b0;
        checks++;
        if (reg_write_en !== 1'b1 || reg_write_dest !== 6'd5 || reg_write_data !== 16'h1234) begin
            errors++;
            $display("FAIL reg_write: en=%b dest=%0d data=%h required 1/5/1234",
                     reg_write_en, reg_write_dest, reg_write_data);
        end
        step();
        checks++;
        if (reg_write_en !== 1'b0) begin
            errors++;
            $display("FAIL reg_write_pulse: en=%b required 0", reg_write_en);
        end
        in_valid = 1'b1; in_dest = 6'd0; in_data = 16'h7777;
        step();
        in_valid = 1'b0;
        checks++;
        if (reg_write_en !== 1'b0 || reg_write_data !== 16'h7777) begin
            errors++;
            $display("FAIL reg_zero_dest: en=%b data=%h required 0/7777", reg_write_en, reg_write_data);
        end
    endtask

    task automatic test_single_store();
        mem_ready = 1'b1;
        in_valid = 1'b1; in_is_store = 1'b1; in_addr = 16'h0040; in_data = 16'hBEEF;
        step();
        in_valid = 1'b0;
        checks++;
        if (mem_write_en !== 1'b0) begin
            errors++;
            $display("FAIL store_n1: mwe=%b required 0", mem_write_en);
        end
        step();
        checks++;
        if (mem_write_en !== 1'b1 || mem_addr !== 16'h0040 || mem_write_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL store_n2: mwe=%b addr=%h data=%h required 1/0040/BEEF",
                     mem_write_en, mem_addr, mem_write_data);
        end
        step();
        checks++;
        if (mem_write_en !== 1'b0 || sb_empty !== 1'b1) begin
            errors++;
            $display("FAIL store_n3: mwe=%b empty=%b required 0/1", mem_write_en, sb_empty);
        end
    endtask

    task automatic test_full();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_is_store = 1'b1;
            in_addr = 16'($urandom); in_data = 16'hA0 + 16'(i);
            step();
        end
        in_data = 16'hA4;
        checks++;
        if (sb_count !== 3'd4 || in_ready !== 1'b0 || mem_write_en !== 1'b1 || mem_write_data !== 16'hA0) begin
            errors++;
            $display("FAIL full_state: cnt=%0d rdy=%b mwe=%b data=%h required 4/0/1/00A0",
                     sb_count, in_ready, mem_write_en, mem_write_data);
        end
        step();
        in_is_store = 1'b0; in_dest = 6'd7; in_data = 16'h5555;
        step();
        checks++;
        if (sb_count !== 3'd4 || reg_write_en !== 1'b0 || mem_write_data !== 16'hA0) begin
            errors++;
            $display("FAIL full_reject: cnt=%0d rwe=%b data=%h required 4/0/00A0",
                     sb_count, reg_write_en, mem_write_data);
        end
        in_valid = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_write_en !== 1'b1 || mem_write_data !== 16'hA0 + 16'(i)) begin
                errors++;
                $display("FAIL full_drain_%0d: mwe=%b data=%h required 1/%h",
                         i, mem_write_en, mem_write_data, 16'hA0 + 16'(i));
            end
            step();
        end
        checks++;
        if (mem_write_en !== 1'b0 || sb_empty !== 1'b1) begin
            errors++;
            $display("FAIL full_drained: mwe=%b empty=%b required 0/1", mem_write_en, sb_empty);
        end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int cyc = 0;
        int hs0 = hs_cnt;
        int pat[5] = '{1, 0, 1, 1, 0};
        while ((sent < 10 || !sb_empty) && cyc < 300) begin
            mem_ready   = pat[cyc % 5][0];
            in_valid    = (sent < 10);
            in_is_store = 1'b1;
            in_addr     = 16'($urandom);
            in_data     = 16'($urandom);
            if (in_valid && in_ready) sent++;
            checks++;
            if (sb_count > 3'd4) begin
                errors++;
                $display("FAIL wrap_count_bound: cnt=%0d required <=4", sb_count);
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (hs_cnt - hs0 != 10 || cyc >= 300) begin
            errors++;
            $display("FAIL wrap_total: handshakes=%0d required 10 (cycles %0d)", hs_cnt - hs0, cyc);
        end
    endtask

    task automatic test_mixed();
        logic [5:0]  d;
        logic [15:0] v;
        mem_ready = 1'b0;
        in_valid = 1'b1; in_is_store = 1'b1; in_addr = 16'h0100; in_data = 16'h00C0;
        step();
        for (int i = 0; i < 6; i++) begin
            if (i % 3 == 2) begin
                in_is_store = 1'b1; in_addr = 16'($urandom); in_data = 16'($urandom);
                step();
                checks++;
                if (reg_write_en !== 1'b0) begin
                    errors++;
                    $display("FAIL mixed_store_%0d: rwe=%b required 0", i, reg_write_en);
                end
            end else begin
                d = 6'($urandom_range(1, 63));
                v = 16'($urandom);
                in_is_store = 1'b0; in_dest = d; in_data = v;
                step();
                checks++;
                if (reg_write_en !== 1'b1 || reg_write_dest !== d || reg_write_data !== v) begin
                    errors++;
                    $display("FAIL mixed_reg_%0d: en=%b dest=%0d data=%h required 1/%0d/%h",
                             i, reg_write_en, reg_write_dest, reg_write_data, d, v);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (sb_count !== 3'd3 || mem_write_data !== 16'h00C0) begin
            errors++;
            $display("FAIL mixed_stalled: cnt=%0d data=%h required 3/00C0", sb_count, mem_write_data);
        end
        drain();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_is_store = 1'b0; in_data = 16'h0;
        in_addr = 16'h0; in_dest = 6'd0; mem_ready = 1'b0;
        step();
        test_reset();
        test_reg_write();
        test_single_store();
        test_full();
        test_wrap();
        test_mixed();
        step();
        checks++;
        if (exp_q.size() != 0 || sb_count !== 3'd0) begin
            errors++;
            $display("FAIL final_empty: model=%0d cnt=%0d required 0/0", exp_q.size(), sb_count);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
